// File: rtl/ahb_pkg.sv
// AHB encodings shared by the arbiter slice: transfer types, burst types, arbiter states.
// Latency: none (types and constants only).
// Backpressure: none.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ARB_PARK   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_BURST  = 2'd2,
        ARB_LOCKED = 2'd3
    } arb_state_e;

    // Beats still to come after the NONSEQ beat of a fixed-length burst.
    localparam int                 BEATS_W  = 4;
    localparam logic [BEATS_W-1:0] BEATS_4  = 4'd3;
    localparam logic [BEATS_W-1:0] BEATS_8  = 4'd7;
    localparam logic [BEATS_W-1:0] BEATS_16 = 4'd15;

    // Counter load value for a NONSEQ of the given burst type; SINGLE/INCR have no fixed tail.
    function automatic logic [BEATS_W-1:0] burst_tail_beats(input logic [2:0] hburst);
        case (hburst_e'(hburst))
            BURST_WRAP4,  BURST_INCR4:  return BEATS_4;
            BURST_WRAP8,  BURST_INCR8:  return BEATS_8;
            BURST_WRAP16, BURST_INCR16: return BEATS_16;
            default:                    return '0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signal bundle between the AHB masters/bus muxes and the arbiter.
// Latency: none (wires only).
// Backpressure: HREADY is the only stall; it is carried here as a plain input to the arbiter.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS  = 2,
    parameter int MASTER_IDX_W = 1
) ();

    logic [NUM_MASTERS-1:0]  HBUSREQ;
    logic [NUM_MASTERS-1:0]  HLOCK;
    logic [1:0]              HTRANS;
    logic [2:0]              HBURST;
    logic                    HREADY;
    logic                    HRESP;
    logic [NUM_MASTERS-1:0]  HGRANT;
    logic [MASTER_IDX_W-1:0] HMASTER;
    logic                    HMASTLOCK;

    // Arbiter side: consumes requests and bus status, produces grant/ownership.
    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTLOCK
    );

    // Master/mux side: raises requests and follows the grant.
    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTLOCK
    );

endinterface

// File: rtl/ahb_burst_counter.sv
// Tracks address beats remaining in the current owner's fixed-length burst.
// Latency: updates on the HREADY-high edge that accepts the address; ERROR clears it one cycle early.
// Backpressure: holds while HREADY is low, except the first ERROR cycle which terminates the burst.
module ahb_burst_counter
    import ahb_pkg::*;
(
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    input  logic               HRESP,
    output logic [BEATS_W-1:0] beats_left
);

    // Load on NONSEQ, count down on SEQ, drop the burst on the first ERROR cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beats_left <= '0;
        end else if (HRESP && !HREADY) begin
            beats_left <= '0;
        end else if (HREADY) begin
            case (htrans_e'(HTRANS))
                TRANS_NONSEQ: beats_left <= burst_tail_beats(HBURST);
                TRANS_SEQ: begin
                    if (beats_left != '0) begin
                        beats_left <= beats_left - BEATS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB arbiter: one-hot HGRANT, HMASTER/HMASTLOCK for the address mux; parks on master 0.
// Latency: request->HGRANT 1 cycle at an arbitration point; HGRANT->HMASTER next HREADY-high edge.
// Backpressure: HREADY low freezes grant and ownership; bursts and locks defer re-arbitration.
// Build option: define ARB_FIXED_PRIORITY_EN for lowest-index-wins instead of round robin.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS  = 2,
    parameter int MASTER_IDX_W = 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_bus_arbiter_if.slave bus
);

    logic [BEATS_W-1:0]      beats_left;
    logic [MASTER_IDX_W-1:0] grant_idx;
    logic [MASTER_IDX_W-1:0] win_idx;
    logic [NUM_MASTERS-1:0]  nxt_grant;
    logic                    win_found;
    logic                    lock_active;
    logic                    rearb_ok;
    logic                    any_req;
    logic                    keep_owner;
    arb_state_e              state;
`ifndef ARB_FIXED_PRIORITY_EN
    logic [MASTER_IDX_W-1:0] rr_ptr;
`endif

    ahb_burst_counter u_burst_counter (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HTRANS     (bus.HTRANS),
        .HBURST     (bus.HBURST),
        .HREADY     (bus.HREADY),
        .HRESP      (bus.HRESP),
        .beats_left (beats_left)
    );

    // Encode the one-hot grant into the index of the granted master.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (bus.HGRANT[i]) begin
                grant_idx = MASTER_IDX_W'(i);
            end
        end
    end

    // A lock is live from HLOCK of the grantee until the locked address phase has left the bus.
    assign lock_active = bus.HLOCK[grant_idx] | bus.HMASTLOCK;
    // beats_left==1 lets the next owner be granted while the last beat's address is accepted.
    assign rearb_ok    = bus.HREADY & ~lock_active & (beats_left <= BEATS_W'(1));
    assign any_req     = |bus.HBUSREQ;
    // An undefined-length INCR keeps the bus as long as its master keeps asking.
    assign keep_owner  = bus.HBUSREQ[grant_idx] && (beats_left == '0) &&
                         (bus.HBURST == BURST_INCR);

    // Pick the next owner; the winner closest to the search start is assigned last.
    always_comb begin
        int                      cand;
        logic [MASTER_IDX_W-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        if (keep_owner) begin
            win_found = 1'b1;
            win_idx   = grant_idx;
        end else begin
`ifdef ARB_FIXED_PRIORITY_EN
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                cand_idx = MASTER_IDX_W'(i);
                if (bus.HBUSREQ[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
`else
            for (int i = NUM_MASTERS; i >= 1; i--) begin
                cand = int'(rr_ptr) + i;
                if (cand >= NUM_MASTERS) begin
                    cand = cand - NUM_MASTERS;
                end
                cand_idx = MASTER_IDX_W'(cand);
                if (bus.HBUSREQ[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
`endif
        end
        nxt_grant = '0;
        if (win_found) begin
            nxt_grant[win_idx] = 1'b1;
        end else begin
            nxt_grant[0] = 1'b1;
        end
    end

    // Arbiter FSM: grant at arbitration points, ownership on accepted address phases.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state         <= ARB_PARK;
            bus.HGRANT    <= NUM_MASTERS'(1);
            bus.HMASTER   <= '0;
            bus.HMASTLOCK <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_ptr        <= '0;
`endif
        end else begin
            // Already parked on master 0 with nobody asking: nothing to re-arbitrate.
            if (rearb_ok && !(state == ARB_PARK && !any_req)) begin
                bus.HGRANT <= nxt_grant;
`ifndef ARB_FIXED_PRIORITY_EN
                if (win_found) begin
                    rr_ptr <= win_idx;
                end
`endif
            end

            if (bus.HREADY) begin
                bus.HMASTER   <= grant_idx;
                bus.HMASTLOCK <= bus.HLOCK[grant_idx];
            end

            if (lock_active) begin
                state <= ARB_LOCKED;
            end else if (rearb_ok) begin
                state <= any_req ? ARB_OWNED : ARB_PARK;
            end else if (beats_left > BEATS_W'(1)) begin
                state <= ARB_BURST;
            end else if (state == ARB_LOCKED) begin
                state <= ARB_OWNED;
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter with two masters.
// Latency: each step drives one cycle of inputs and checks outputs 1 time unit after the edge.
// Backpressure: HREADY/HRESP are driven per step to exercise stalls and ERROR termination.
module tb_ahb_bus_arbiter;

    localparam int NM = 2;
    localparam int IW = 1;
`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    localparam logic [1:0] T_ID  = 2'd0;
    localparam logic [1:0] T_NS  = 2'd2;
    localparam logic [1:0] T_SQ  = 2'd3;
    localparam logic [2:0] B_SGL = 3'd0;
    localparam logic [2:0] B_INC = 3'd1;
    localparam logic [2:0] B_I4  = 3'd3;
    localparam logic [2:0] B_I8  = 3'd5;
    localparam logic [2:0] B_I16 = 3'd7;
    localparam logic [1:0] G0    = 2'b01;
    localparam logic [1:0] G1    = 2'b10;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    ahb_bus_arbiter_if #(.NUM_MASTERS(NM), .MASTER_IDX_W(IW)) bus ();

    ahb_bus_arbiter #(.NUM_MASTERS(NM), .MASTER_IDX_W(IW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string      tag;
        logic [1:0] grant;
        logic       master;
        logic       mlock;
        logic [3:0] beats;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] req, input logic [1:0] lck,
                        input logic [1:0] trans, input logic [2:0] burst,
                        input logic rdy, input logic resp,
                        input logic [1:0] g, input logic m, input logic ml,
                        input logic [3:0] b);
        exp_t e;
        bus.HBUSREQ = req;
        bus.HLOCK   = lck;
        bus.HTRANS  = trans;
        bus.HBURST  = burst;
        bus.HREADY  = rdy;
        bus.HRESP   = resp;
        e.tag    = tag;
        e.grant  = g;
        e.master = m;
        e.mlock  = ml;
        e.beats  = b;
        sb.push_back(e);
        @(posedge HCLK);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq({e.tag, ".grant"},  32'(bus.HGRANT),          32'(e.grant));
            check_eq({e.tag, ".master"}, 32'(bus.HMASTER),         32'(e.master));
            check_eq({e.tag, ".mlock"},  32'(bus.HMASTLOCK),       32'(e.mlock));
            check_eq({e.tag, ".beats"},  32'(dut.beats_left),      32'(e.beats));
            check_eq({e.tag, ".onehot"}, 32'($onehot(bus.HGRANT)), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HTRANS  = T_ID;
        bus.HBURST  = B_SGL;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 1'b0;

        // Reset values while held in reset across clock edges.
        repeat (2) @(posedge HCLK);
        #1;
        check_eq("rst.grant",  32'(bus.HGRANT),     32'(G0));
        check_eq("rst.master", 32'(bus.HMASTER),    32'd0);
        check_eq("rst.mlock",  32'(bus.HMASTLOCK),  32'd0);
        check_eq("rst.beats",  32'(dut.beats_left), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Parked, no requests.
        for (int i = 0; i < 10; i++) begin
            step("idle", 2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);
        end

        // Master 1 alone: grant next edge, ownership the edge after.
        step("m1req_a",  2'b10, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G1, 1'b0, 1'b0, 4'd0);
        step("m1req_b",  2'b10, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G1, 1'b1, 1'b0, 4'd0);
        step("m1single", 2'b00, 2'b00, T_NS, B_SGL, 1'b1, 1'b0, G0, 1'b1, 1'b0, 4'd0);
        step("m1park",   2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);

        // Master 0 INCR4, master 1 asks during the burst; handover on the 4th address.
        step("i4_req0",  2'b01, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);
        step("i4_ns",    2'b01, 2'b00, T_NS, B_I4,  1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd3);
        step("i4_s1",    2'b10, 2'b00, T_SQ, B_I4,  1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd2);
        step("i4_s2",    2'b10, 2'b00, T_SQ, B_I4,  1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd1);
        step("i4_s3",    2'b10, 2'b00, T_SQ, B_I4,  1'b1, 1'b0, G1, 1'b0, 1'b0, 4'd0);
        step("i4_hand",  2'b10, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G1, 1'b1, 1'b0, 4'd0);
        step("i4_m1sgl", 2'b00, 2'b00, T_NS, B_SGL, 1'b1, 1'b0, G0, 1'b1, 1'b0, 4'd0);
        step("i4_park",  2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);

        // Both masters request continuously with SINGLE transfers.
        for (int k = 0; k < 6; k++) begin
            step("rr_alt", 2'b11, 2'b00, T_NS, B_SGL, 1'b1, 1'b0,
                 FP ? G0 : ((k % 2 == 0) ? G0 : G1),
                 FP ? 1'b0 : ((k >= 2 && k % 2 == 0) ? 1'b1 : 1'b0),
                 1'b0, 4'd0);
        end
        step("rr_drain0", 2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, FP ? 1'b0 : 1'b1, 1'b0, 4'd0);
        step("rr_drain1", 2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);

        // Master 1 locked for three transfers while master 0 keeps asking.
        step("lk_grant", 2'b10, 2'b10, T_ID, B_SGL, 1'b1, 1'b0, G1, 1'b0, 1'b0, 4'd0);
        step("lk_own",   2'b11, 2'b10, T_ID, B_SGL, 1'b1, 1'b0, G1, 1'b1, 1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            step("lk_xfer", 2'b11, 2'b10, T_NS, B_SGL, 1'b1, 1'b0, G1, 1'b1, 1'b1, 4'd0);
        end
        step("lk_drop",  2'b01, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G1, 1'b1, 1'b0, 4'd0);
        step("lk_rearb", 2'b01, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b1, 1'b0, 4'd0);
        step("lk_m0own", 2'b01, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);

        // INCR8 terminated by a two-cycle ERROR on beat 3.
        step("er_ns",    2'b01, 2'b00, T_NS, B_I8,  1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd7);
        step("er_s1",    2'b11, 2'b00, T_SQ, B_I8,  1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd6);
        step("er_s2",    2'b11, 2'b00, T_SQ, B_I8,  1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd5);
        step("er_err1",  2'b11, 2'b00, T_SQ, B_I8,  1'b0, 1'b1, G0, 1'b0, 1'b0, 4'd0);
        step("er_err2",  2'b10, 2'b00, T_ID, B_I8,  1'b1, 1'b1, G1, 1'b0, 1'b0, 4'd0);
        step("er_park",  2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b1, 1'b0, 4'd0);
        step("er_idle",  2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);

        // Reset in the middle of a locked INCR16 owned by master 1.
        step("mr_grant", 2'b10, 2'b10, T_ID, B_SGL, 1'b1, 1'b0, G1, 1'b0, 1'b0, 4'd0);
        step("mr_ns",    2'b10, 2'b10, T_NS, B_I16, 1'b1, 1'b0, G1, 1'b1, 1'b1, 4'd15);
        step("mr_s1",    2'b10, 2'b10, T_SQ, B_I16, 1'b1, 1'b0, G1, 1'b1, 1'b1, 4'd14);
        #3;
        HRESETn = 1'b0;
        #1;
        check_eq("mr.grant",  32'(bus.HGRANT),     32'(G0));
        check_eq("mr.master", 32'(bus.HMASTER),    32'd0);
        check_eq("mr.mlock",  32'(bus.HMASTLOCK),  32'd0);
        check_eq("mr.beats",  32'(dut.beats_left), 32'd0);
        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HTRANS  = T_ID;
        bus.HBURST  = B_SGL;
        @(negedge HCLK);
        HRESETn = 1'b1;
        step("mr_post",  2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);

        // Undefined-length INCR keeps the bus while its master keeps requesting.
        step("kp_ns",    2'b11, 2'b00, T_NS, B_INC, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);
        step("kp_seq",   2'b11, 2'b00, T_SQ, B_INC, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);
        step("kp_end",   2'b11, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, FP ? G0 : G1, 1'b0, 1'b0, 4'd0);
        step("kp_drain", 2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, FP ? 1'b0 : 1'b1, 1'b0, 4'd0);
        step("kp_idle",  2'b00, 2'b00, T_ID, B_SGL, 1'b1, 1'b0, G0, 1'b0, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
